ccc_clken_supervisor: RTL and testbench
=======================================

CCC_CLKEN_SUPERVISOR -- requirements
Module: ccc_clken_supervisor

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of divided clock-enable channels (1..8).
REQ-002 SHALL have parameter DIV_W, default 7, width of each channel divide value.
REQ-003 SHALL have parameter PWRDN_CYC, default 64, cycles PLL_POWERDOWN_N is held low per power-down.
REQ-004 SHALL have parameter STABLE_CYC, default 1024, cycles lock must hold before RUN.
REQ-005 SHALL have parameter LOCK_TMO, default 65535, WAIT_LOCK timeout in cycles.
REQ-006 SHALL have port CLK  in  1  single fabric clock; all logic on rising edge.
REQ-007 SHALL have port RESET_N  in  1  asynchronous active-low reset.
REQ-008 SHALL have port PLL_LOCK  in  1  PLL lock, asynchronous to CLK.
REQ-009 SHALL have port PLL_POWERDOWN_N  out  1  PLL power-down control, active low.
REQ-010 SHALL have port DIV_VAL  in  NUM_CH*DIV_W  per-channel divide value, channel 0 in the LSBs.
REQ-011 SHALL have port OUT_EN  in  NUM_CH  per-channel enable.
REQ-012 SHALL have port CLK_EN  out  NUM_CH  per-channel one-cycle clock-enable pulses.
REQ-013 SHALL have port CH_RST_N  out  NUM_CH  per-channel synchronous reset, active low.
REQ-014 SHALL have port READY  out  1  high in RUN only.
REQ-015 SHALL have port LOCK_LOST  out  1  sticky flag for lock loss in RUN.
REQ-016 SHALL have port CLR_STICKY  in  1  clears LOCK_LOST and RETRY_CNT.
REQ-017 SHALL have port RETRY_CNT  out  4  count of WAIT_LOCK timeouts, saturating at 15.

Function
REQ-018 SHALL pass PLL_LOCK through a 2-flop synchronizer; all uses below refer to the synchronized value, lock_s.
REQ-019 SHALL implement FSM states PWRDN, WAIT_LOCK, STABLE, RUN.
REQ-020 PWRDN SHALL drive PLL_POWERDOWN_N=0 for PWRDN_CYC cycles, then go to WAIT_LOCK.
REQ-021 WAIT_LOCK SHALL drive PLL_POWERDOWN_N=1 and go to STABLE on lock_s=1.
REQ-022 WAIT_LOCK SHALL, after LOCK_TMO cycles without lock, take the timeout action defined under Configuration.
REQ-023 STABLE SHALL count consecutive lock_s=1 cycles and go to RUN after STABLE_CYC cycles.
REQ-024 STABLE SHALL return to WAIT_LOCK on lock_s=0, restarting its timeout counter.
REQ-025 RUN SHALL, on lock_s=0, set LOCK_LOST and go to PWRDN in the next cycle.
REQ-026 On RUN exit, all CLK_EN and CH_RST_N outputs SHALL go 0 in that same cycle.
REQ-027 On RUN entry, CH_RST_N[i] SHALL deassert i+1 cycles later (staggered release).
REQ-028 Each channel SHALL have a DIV_W-bit counter, zeroed on RUN entry and while OUT_EN[i]=0.
REQ-029 CLK_EN[i] SHALL be a registered pulse, high when counter=d-1, where d=DIV_VAL[i] and d=0 is treated as 1; the counter SHALL then wrap to 0.
REQ-030 d=1 SHALL give CLK_EN[i] continuously high while enabled.
REQ-031 DIV_VAL[i] SHALL be sampled only at counter=0, so a change mid-period SHALL take effect from the next period with no short pulse.
REQ-032 CLK_EN[i] SHALL be 0 while CH_RST_N[i]=0 or OUT_EN[i]=0; all enabled channels SHALL start counting together on RUN entry, so equal divisors are phase-aligned.
REQ-033 If CLR_STICKY and a set event occur in the same cycle, the set SHALL win.

Reset
REQ-034 RESET_N=0 SHALL asynchronously force state PWRDN with counters zero, PLL_POWERDOWN_N=0, CLK_EN=0, CH_RST_N=0, READY=0, LOCK_LOST=0, RETRY_CNT=0 and synchronizer flops 0.
REQ-035 Reset deassertion mid-operation SHALL restart the full PWRDN sequence.

Configuration
REQ-036 With macro CCC_LOCK_RETRY_EN defined, a WAIT_LOCK timeout SHALL increment RETRY_CNT (saturating) and go to PWRDN.
REQ-037 Without CCC_LOCK_RETRY_EN, WAIT_LOCK SHALL wait indefinitely, the timeout counter SHALL not exist, and RETRY_CNT SHALL be tied to 0.

Verification
REQ-038 Raise PLL_LOCK 10 cycles after PWRDN ends with defaults -> READY=1 about 1026 cycles later; CH_RST_N[0..3] release on consecutive cycles.
REQ-039 DIV_VAL={4,3,1,0} with all OUT_EN=1 -> CLK_EN[0] every 4 cycles, CLK_EN[1] every 3 cycles, CLK_EN[2] and CLK_EN[3] constantly high; CLK_EN[0] and CLK_EN[1] coincide every 12 cycles.
REQ-040 Change DIV_VAL[0] from 4 to 2 mid-period -> the current 4-cycle period completes, then pulses every 2 cycles, with no extra pulse.
REQ-041 Drop PLL_LOCK in RUN -> LOCK_LOST=1, CLK_EN=0 and READY=0 within 3 cycles, PLL_POWERDOWN_N=0 for 64 cycles; CLR_STICKY then clears LOCK_LOST.
REQ-042 Hold PLL_LOCK=0 with CCC_LOCK_RETRY_EN defined -> RETRY_CNT increments per 65535-cycle timeout and saturates at 15; without the macro -> no power-down recurs.
REQ-043 Glitch PLL_LOCK low for 1 cycle in STABLE -> the stable count restarts and RUN entry is delayed accordingly.

Source files
------------

// File: rtl/ccc_clken_supervisor.sv
// ccc_clken_supervisor: PLL power-up/lock supervisor with per-channel divided clock enables.
// The PLL is held in power-down, then the supervisor waits for lock and a lock-stable window.
// Divided enables and staggered channel resets run only while the supervisor is in RUN.
// Optional feature macro CCC_LOCK_RETRY_EN adds a WAIT_LOCK timeout and a retry counter.
// The timeout restarts the power-down sequence; without the macro WAIT_LOCK waits forever.
module ccc_clken_supervisor #(
   parameter int unsigned NUM_CH     = 4,
   parameter int unsigned DIV_W      = 7,
   parameter int unsigned PWRDN_CYC  = 64,
   parameter int unsigned STABLE_CYC = 1024,
   parameter int unsigned LOCK_TMO   = 65535
) (
   input  logic                    CLK,
   input  logic                    RESET_N,
   input  logic                    PLL_LOCK,
   output logic                    PLL_POWERDOWN_N,
   input  logic [NUM_CH*DIV_W-1:0] DIV_VAL,
   input  logic [NUM_CH-1:0]       OUT_EN,
   output logic [NUM_CH-1:0]       CLK_EN,
   output logic [NUM_CH-1:0]       CH_RST_N,
   output logic                    READY,
   output logic                    LOCK_LOST,
   input  logic                    CLR_STICKY,
   output logic [3:0]              RETRY_CNT
);

   localparam int unsigned SEQ_MAX = (PWRDN_CYC > STABLE_CYC) ? PWRDN_CYC : STABLE_CYC;
   localparam int unsigned SEQ_W   = $clog2(SEQ_MAX + 1);

   typedef enum logic [1:0] {ST_PWRDN, ST_WAIT_LOCK, ST_STABLE, ST_RUN} state_t;

   state_t            state_q, state_d;
   logic [1:0]        sync_q, sync_d;
   logic [SEQ_W-1:0]  seq_q, seq_d;
   logic              pwrdn_n_q, pwrdn_n_d;
   logic              ready_q, ready_d;
   logic              lost_q, lost_d;
   logic [NUM_CH-1:0] rst_sr_q, rst_sr_d;
   logic [NUM_CH-1:0] clk_en_q, clk_en_d;
   logic [DIV_W-1:0]  cnt_q [NUM_CH];
   logic [DIV_W-1:0]  cnt_d [NUM_CH];
   logic [DIV_W-1:0]  per_q [NUM_CH];
   logic [DIV_W-1:0]  per_d [NUM_CH];
   logic [DIV_W-1:0]  d_now [NUM_CH];
   logic              lock_s;
   logic              lost_set;
   logic              stay_run;

`ifdef CCC_LOCK_RETRY_EN
   localparam int unsigned TMO_W = $clog2(LOCK_TMO + 1);
   logic [TMO_W-1:0] tmo_q, tmo_d;
   logic [3:0]       retry_q, retry_d;
   logic             retry_inc;
`endif

   assign lock_s = sync_q[1];

   // Supervisor FSM: power-down, lock wait, stability window, run; plus sticky flags
   always_comb begin
      state_d  = state_q;
      seq_d    = '0;
      lost_set = 1'b0;
      sync_d   = {sync_q[0], PLL_LOCK};
`ifdef CCC_LOCK_RETRY_EN
      retry_inc = 1'b0;
`endif
      unique case (state_q)
         ST_PWRDN: begin
            if (seq_q == SEQ_W'(PWRDN_CYC - 1)) state_d = ST_WAIT_LOCK;
            else                                seq_d   = seq_q + SEQ_W'(1);
         end
         ST_WAIT_LOCK: begin
            if (lock_s) state_d = ST_STABLE;
`ifdef CCC_LOCK_RETRY_EN
            else if (tmo_q == TMO_W'(LOCK_TMO - 1)) begin
               state_d   = ST_PWRDN;
               retry_inc = 1'b1;
            end
`endif
         end
         ST_STABLE: begin
            if (!lock_s)                              state_d = ST_WAIT_LOCK;
            else if (seq_q == SEQ_W'(STABLE_CYC - 1)) state_d = ST_RUN;
            else                                      seq_d   = seq_q + SEQ_W'(1);
         end
         ST_RUN: begin
            if (!lock_s) begin
               state_d  = ST_PWRDN;
               lost_set = 1'b1;
            end
         end
         default: state_d = ST_PWRDN;
      endcase

      pwrdn_n_d = (state_d != ST_PWRDN);
      ready_d   = (state_d == ST_RUN);
      // a set event in the same cycle as a clear takes priority
      lost_d    = lost_set ? 1'b1 : (CLR_STICKY ? 1'b0 : lost_q);
`ifdef CCC_LOCK_RETRY_EN
      tmo_d   = ((state_q == ST_WAIT_LOCK) && (state_d == ST_WAIT_LOCK)) ? tmo_q + TMO_W'(1) : '0;
      retry_d = retry_inc ? ((retry_q == 4'd15) ? 4'd15 : retry_q + 4'd1)
                          : (CLR_STICKY ? 4'd0 : retry_q);
`endif
   end

   // Channel dividers: common start on RUN entry, divisor latched at each period start
   always_comb begin
      stay_run = (state_q == ST_RUN) && (state_d == ST_RUN);
      rst_sr_d = stay_run ? ((rst_sr_q << 1) | NUM_CH'(1)) : '0;
      clk_en_d = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (cnt_q[i] == '0)
            d_now[i] = (DIV_VAL[i*DIV_W +: DIV_W] == '0) ? DIV_W'(1) : DIV_VAL[i*DIV_W +: DIV_W];
         else
            d_now[i] = per_q[i];
         per_d[i] = d_now[i];
         cnt_d[i] = '0;
         if (stay_run && OUT_EN[i]) begin
            if (cnt_q[i] == d_now[i] - DIV_W'(1)) begin
               clk_en_d[i] = rst_sr_d[i];
            end else begin
               cnt_d[i] = cnt_q[i] + DIV_W'(1);
            end
         end
      end
   end

   // State and output registers
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q   <= ST_PWRDN;
         sync_q    <= '0;
         seq_q     <= '0;
         pwrdn_n_q <= 1'b0;
         ready_q   <= 1'b0;
         lost_q    <= 1'b0;
         rst_sr_q  <= '0;
         clk_en_q  <= '0;
         for (int i = 0; i < NUM_CH; i++) begin
            cnt_q[i] <= '0;
            per_q[i] <= '0;
         end
`ifdef CCC_LOCK_RETRY_EN
         tmo_q   <= '0;
         retry_q <= '0;
`endif
      end else begin
         state_q   <= state_d;
         sync_q    <= sync_d;
         seq_q     <= seq_d;
         pwrdn_n_q <= pwrdn_n_d;
         ready_q   <= ready_d;
         lost_q    <= lost_d;
         rst_sr_q  <= rst_sr_d;
         clk_en_q  <= clk_en_d;
         for (int i = 0; i < NUM_CH; i++) begin
            cnt_q[i] <= cnt_d[i];
            per_q[i] <= per_d[i];
         end
`ifdef CCC_LOCK_RETRY_EN
         tmo_q   <= tmo_d;
         retry_q <= retry_d;
`endif
      end
   end

   assign PLL_POWERDOWN_N = pwrdn_n_q;
   assign READY           = ready_q;
   assign LOCK_LOST       = lost_q;
   assign CH_RST_N        = rst_sr_q;
   assign CLK_EN          = clk_en_q;
`ifdef CCC_LOCK_RETRY_EN
   assign RETRY_CNT = retry_q;
`else
   // retry feature absent: no timeout, count held at zero
   assign RETRY_CNT = 4'd0;
`endif

endmodule

// File: tb/tb_ccc_clken_supervisor.sv
// Self-checking bench for ccc_clken_supervisor (defaults, LOCK_TMO shortened to 300).
// Expected enables come from a period-schedule model: each period starts at the cycle
// the previous pulse appeared, its length is the divisor driven at that start.
`timescale 1ns/1ps
module tb_ccc_clken_supervisor;

   localparam int NUM_CH     = 4;
   localparam int DIV_W      = 7;
   localparam int PWRDN_CYC  = 64;
   localparam int STABLE_CYC = 1024;
   localparam int LOCK_TMO   = 300;

   logic                    clk = 1'b0;
   logic                    rst_n = 1'b0;
   logic                    pll_lock = 1'b0;
   logic                    pdn_n;
   logic [NUM_CH*DIV_W-1:0] div_val = '0;
   logic [NUM_CH-1:0]       out_en = '0;
   logic [NUM_CH-1:0]       clk_en;
   logic [NUM_CH-1:0]       ch_rst_n;
   logic                    ready;
   logic                    lock_lost;
   logic                    clr_sticky = 1'b0;
   logic [3:0]              retry_cnt;

   int                n_checks = 0;
   int                n_err    = 0;
   int                cyc      = 0;
   int                dv [NUM_CH];
   int                nxt [NUM_CH];
   logic [NUM_CH-1:0] en;

   always #5 clk = ~clk;

   ccc_clken_supervisor #(
      .NUM_CH(NUM_CH), .DIV_W(DIV_W), .PWRDN_CYC(PWRDN_CYC),
      .STABLE_CYC(STABLE_CYC), .LOCK_TMO(LOCK_TMO)
   ) dut (
      .CLK(clk), .RESET_N(rst_n), .PLL_LOCK(pll_lock), .PLL_POWERDOWN_N(pdn_n),
      .DIV_VAL(div_val), .OUT_EN(out_en), .CLK_EN(clk_en), .CH_RST_N(ch_rst_n),
      .READY(ready), .LOCK_LOST(lock_lost), .CLR_STICKY(clr_sticky), .RETRY_CNT(retry_cnt)
   );

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s at cycle %0d: observed=%0d expected=%0d", tag, cyc, obs, exp);
      end
   endtask

   function automatic logic [NUM_CH*DIV_W-1:0] pack_div();
      logic [NUM_CH*DIV_W-1:0] p;
      for (int i = 0; i < NUM_CH; i++) p[i*DIV_W +: DIV_W] = DIV_W'(dv[i]);
      return p;
   endfunction

   function automatic int eff(input int d);
      return (d == 0) ? 1 : d;
   endfunction

   // count consecutive cycles with power-down asserted, starting now
   task automatic measure_low(input string tag, input int exp);
      int n = 0;
      while (pdn_n === 1'b0 && n < 4000) begin n++; tick(); end
      chk(tag, n, exp);
   endtask

   // lock is driven high at cycle l; checks READY, channel resets and enables until t0+len
   task automatic sess(input int l, input int len, input int chg_off, input int chg_ch, input int chg_val);
      int t0 = l + 3 + STABLE_CYC;
      for (int i = 0; i < NUM_CH; i++) nxt[i] = -1;
      while (cyc < t0 + len) begin
         logic [NUM_CH-1:0] e_rst, e_en;
         for (int i = 0; i < NUM_CH; i++) begin
            e_rst[i] = (cyc - t0 >= i + 1);
            e_en[i]  = e_rst[i] && en[i] && (cyc == nxt[i]);
         end
         chk("ready", 32'(ready), 32'(cyc >= t0));
         chk("ch_rst_n", 32'(ch_rst_n), 32'(e_rst));
         chk("clk_en", 32'(clk_en), 32'(e_en));
         if (chg_off >= 0 && cyc == t0 + chg_off) begin
            dv[chg_ch] = chg_val;
            div_val    = pack_div();
         end
         for (int i = 0; i < NUM_CH; i++)
            if (cyc == t0 || (cyc > t0 && cyc == nxt[i])) nxt[i] = cyc + eff(dv[i]);
         tick();
      end
   endtask

   // lock loss in RUN, optionally with CLR_STICKY held across the set event
   task automatic drop(input bit clr_hold);
      pll_lock   = 1'b0;
      clr_sticky = clr_hold;
      tick();
      chk("ready_hold1", 32'(ready), 1);
      tick();
      chk("ready_hold2", 32'(ready), 1);
      tick();
      clr_sticky = 1'b0;
      chk("ready_drop", 32'(ready), 0);
      chk("lock_lost_set", 32'(lock_lost), 1);
      chk("clk_en_drop", 32'(clk_en), 0);
      chk("ch_rst_drop", 32'(ch_rst_n), 0);
      measure_low("pwrdn_after_loss", PWRDN_CYC);
      chk("lock_lost_sticky", 32'(lock_lost), 1);
      clr_sticky = 1'b1;
      tick();
      clr_sticky = 1'b0;
      chk("lock_lost_clr", 32'(lock_lost), 0);
   endtask

   initial begin
      // reset values
      repeat (3) tick();
      chk("rst_pdn_n", 32'(pdn_n), 0);
      chk("rst_clk_en", 32'(clk_en), 0);
      chk("rst_ch_rst_n", 32'(ch_rst_n), 0);
      chk("rst_ready", 32'(ready), 0);
      chk("rst_lock_lost", 32'(lock_lost), 0);
      chk("rst_retry", 32'(retry_cnt), 0);
      rst_n = 1'b1;
      measure_low("pwrdn_len", PWRDN_CYC);

      // divisors 4,3,1,0 with a 4->2 change on channel 0 mid-period
      dv[0] = 4; dv[1] = 3; dv[2] = 1; dv[3] = 0;
      en = '1; out_en = en; div_val = pack_div();
      repeat (10) tick();
      pll_lock = 1'b1;
      sess(cyc, 80, 30, 0, 2);
      drop(1'b1);

      // randomized divisors, enables and a mid-session divisor change
      for (int r = 0; r < 4; r++) begin
         for (int i = 0; i < NUM_CH; i++) dv[i] = int'($urandom_range(0, 9));
         en = 4'($urandom_range(0, 15)); out_en = en; div_val = pack_div();
         repeat (int'($urandom_range(1, 20))) tick();
         pll_lock = 1'b1;
         sess(cyc, 60, int'($urandom_range(5, 40)), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 9)));
         drop(r % 2 == 1);
      end

      // one-cycle lock glitch in STABLE restarts the stable window
      dv[0] = 2; dv[1] = 2; dv[2] = 5; dv[3] = 1;
      en = '1; out_en = en; div_val = pack_div();
      repeat (5) tick();
      pll_lock = 1'b1;
      repeat (500) tick();
      pll_lock = 1'b0;
      tick();
      pll_lock = 1'b1;
      sess(cyc, 30, -1, 0, 0);

      // reset asserted in RUN forces everything low and restarts power-down
      rst_n = 1'b0;
      #1;
      chk("midrst_ready", 32'(ready), 0);
      chk("midrst_clk_en", 32'(clk_en), 0);
      chk("midrst_ch_rst_n", 32'(ch_rst_n), 0);
      chk("midrst_pdn_n", 32'(pdn_n), 0);
      pll_lock = 1'b0;
      tick();
      rst_n = 1'b1;
      measure_low("pwrdn_after_rst", PWRDN_CYC);

      // lock held low
`ifdef CCC_LOCK_RETRY_EN
      for (int k = 1; k <= 17; k++) begin
         int hi = 0;
         while (pdn_n === 1'b1 && hi < LOCK_TMO + 100) begin hi++; tick(); end
         chk("wait_lock_tmo", hi, LOCK_TMO);
         chk("retry_cnt", 32'(retry_cnt), (k > 15) ? 15 : k);
         measure_low("pwrdn_retry", PWRDN_CYC);
      end
      clr_sticky = 1'b1;
      tick();
      clr_sticky = 1'b0;
      chk("retry_clr", 32'(retry_cnt), 0);
`else
      begin
         int lowc = 0;
         repeat (3000) begin
            tick();
            if (pdn_n !== 1'b1) lowc++;
         end
         chk("no_repowerdown", lowc, 0);
         chk("retry_tied", 32'(retry_cnt), 0);
      end
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
